// File: rtl/trace_capture_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : trace_capture_buffer_if
//  Description : Capture-side controls, event input and drain stream of the
//                trace capture buffer. The master modport is the producer /
//                consumer environment; the slave modport is the buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface trace_capture_buffer_if #(
    parameter int DATA_W = 8,
    parameter int NCH    = 2,
    parameter int TS_W   = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
);
    logic                      io_en;
    logic                      io_mode;
    logic                      io_in_valid;
    logic [NCH*DATA_W-1:0]     io_in_data;
    logic                      io_out_valid;
    logic                      io_out_ready;
    logic [TS_W-1:0]           io_out_ts;
    logic [NCH*DATA_W-1:0]     io_out_data;
    logic                      io_out_lost;
    logic [$clog2(DEPTH):0]    io_count;
    logic [CNT_W-1:0]          io_drop_count;

    modport master (
        output io_en, io_mode, io_in_valid, io_in_data, io_out_ready,
        input  io_out_valid, io_out_ts, io_out_data, io_out_lost,
               io_count, io_drop_count
    );

    modport slave (
        input  io_en, io_mode, io_in_valid, io_in_data, io_out_ready,
        output io_out_valid, io_out_ts, io_out_data, io_out_lost,
               io_count, io_drop_count
    );
endinterface
`default_nettype wire

// File: rtl/trace_capture_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : trace_capture_buffer
//  Description : Samples NCH debug channels, stamps each captured event with
//                a free-running cycle counter and queues {lost, ts, data} in
//                a DEPTH-entry FIFO drained by a ready/valid stream. Supports
//                change-only capture, saturating drop counting and a lost
//                marker on the first entry accepted after drops.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_capture_buffer #(
    parameter int DATA_W = 8,
    parameter int NCH    = 2,
    parameter int TS_W   = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    trace_capture_buffer_if.slave  bus
);
    localparam int              W          = NCH * DATA_W;
    localparam int              PTR_W      = $clog2(DEPTH);
    localparam int              CW         = PTR_W + 1;
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

    // Free-running timestamp counter
    logic [TS_W-1:0]   r_tsc;

    // FIFO storage; entries are not reset, occupancy decides validity
    logic [TS_W-1:0]   r_mem_ts   [DEPTH];
    logic [W-1:0]      r_mem_data [DEPTH];
    logic              r_mem_lost [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [CNT_W-1:0]  r_drop_count;
    logic              r_lost_pending;
    logic [W-1:0]      r_last_data;
    logic              r_last_vld;

    logic              w_full;
    logic              w_pop;
    logic              w_cand;
    logic              w_push;
    logic              w_drop;

    // Event qualification and FIFO handshake decisions for this cycle
    always_comb begin
        w_full = (r_count == FULL_COUNT);
        w_pop  = (r_count != '0) && bus.io_out_ready;
        w_cand = bus.io_en && bus.io_in_valid &&
                 (!bus.io_mode || !r_last_vld || (bus.io_in_data != r_last_data));
        // A full FIFO still accepts when the head leaves at the same edge
        w_push = w_cand && (!w_full || w_pop);
        w_drop = w_cand && !w_push;
    end

    // Timestamp counter, wraps silently
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tsc <= '0;
        end else begin
            r_tsc <= r_tsc + 1'b1;
        end
    end

    // Entry write into the FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ts[r_wr_ptr]   <= r_tsc;
            r_mem_data[r_wr_ptr] <= bus.io_in_data;
            r_mem_lost[r_wr_ptr] <= r_lost_pending;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Drop accounting, lost marker and change-detection reference
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count   <= '0;
            r_lost_pending <= 1'b0;
            r_last_data    <= '0;
            r_last_vld     <= 1'b0;
        end else if (w_push) begin
            r_lost_pending <= 1'b0;
            r_last_data    <= bus.io_in_data;
            r_last_vld     <= 1'b1;
        end else if (w_drop) begin
            // Dropped values do not update the reference, so a repeat of a
            // dropped value remains a candidate in change-only mode
            r_lost_pending <= 1'b1;
            if (r_drop_count != {CNT_W{1'b1}}) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    assign bus.io_out_valid  = (r_count != '0);
    assign bus.io_out_ts     = r_mem_ts[r_rd_ptr];
    assign bus.io_out_data   = r_mem_data[r_rd_ptr];
    assign bus.io_out_lost   = r_mem_lost[r_rd_ptr];
    assign bus.io_count      = r_count;
    assign bus.io_drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: doc/trace_capture_buffer.md
Name: trace_capture_buffer

Overview:
Parametrised successor to the single-shot cycle-stamped debug printf. Samples NCH channels of DATA_W-bit debug data, stamps each captured event with a free-running TS_W-bit cycle counter and buffers {lost, timestamp, data} in a DEPTH-entry FIFO. A ready/valid stream drains the FIFO to a host or trace port. Adds change-only capture mode, overflow accounting and a lost-event marker.

Parameters:
DATA_W, 8, width of one channel
NCH, 2, number of channels; io_in_data packs channel 0 in the LSBs
TS_W, 32, timestamp counter width
DEPTH, 16, FIFO entries; power of 2, minimum 2
CNT_W, 16, drop counter width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
io_en  in  1  capture enable
io_mode  in  1  0 = capture every valid event; 1 = capture only when data differs from last captured
io_in_valid  in  1  event present this cycle
io_in_data  in  NCH*DATA_W  packed channel data
io_out_valid  out  1  FIFO head valid
io_out_ready  in  1  consumer accepts head
io_out_ts  out  TS_W  timestamp of head entry
io_out_data  out  NCH*DATA_W  data of head entry
io_out_lost  out  1  set on the first entry accepted after one or more drops
io_count  out  log2(DEPTH)+1  current occupancy
io_drop_count  out  CNT_W  dropped events, saturating

Behaviour:
- Reset: tsc=0, FIFO empty, io_out_valid=0, io_count=0, io_drop_count=0, lost-pending=0, last-data-valid=0. io_out_ts/io_out_data/io_out_lost are don't-care while io_out_valid=0. Reset mid-stream discards all contents at the same edge.
- tsc: 0 after reset, +1 every cycle not in reset, wraps modulo 2^TS_W with no flag.
- Candidate event: io_en & io_in_valid & (io_mode==0 | !last_vld | io_in_data != last_data).
- Timestamp = tsc value in the cycle the candidate is presented (cycle 0 after reset deassert stamps 0).
- Pop: io_out_valid & io_out_ready, evaluated at the clock edge.
- Push accepted if candidate & (count<DEPTH | pop). When full, simultaneous push and pop both succeed; count unchanged.
- Accepted push: entry.lost = lost_pending; then lost_pending=0; last_data<=io_in_data, last_vld<=1.
- Candidate rejected (full, no pop): io_drop_count+1, saturating at 2^CNT_W-1; lost_pending=1; last_data/last_vld unchanged (a repeat of a dropped value is still a candidate in mode 1).
- Empty FIFO: an entry pushed at edge N is visible with io_out_valid=1 after edge N (1-cycle latency). No same-cycle bypass: pop only from stored entries.
- Head fields stable while io_out_valid=1 and io_out_ready=0.
- io_count = occupancy after the last edge; registered.
- io_en=0 or io_in_valid=0: no capture; drain continues; last_data retained.
- Mode change takes effect on the next candidate evaluation; last_data is not cleared.
- Pointers wrap modulo DEPTH; full/empty distinguished by the extra count bit.

Test Plan:
- Reset, io_en=1, mode 0, valid on cycles 3,4,5 with data 0x1122,0x3344,0x5566, ready=1 -> out entries ts=3,4,5 with those data, lost=0, each visible one cycle after its push.
- Mode 1, data 0x0A0B for 5 cycles then 0x0A0C from ts=10 -> exactly two entries: first with the first ts, second ts=10.
- DEPTH=16, ready=0, 20 valid events -> count=16, drop_count=4; raise ready, push a 21st -> 16 original entries in order, then the 21st with lost=1.
- Full FIFO, ready=1 and push in the same cycle -> push accepted, count stays 16, drop_count unchanged.
- TS_W=4, free-run past 15 -> event timestamps wrap 14,15,0,1.
- Fill 5 entries, assert reset one cycle -> out_valid=0, count=0, drop_count=0; next event stamped 0.
